// File: rtl/driver_cntrl_mc.sv
// driver_cntrl_mc: multi-channel driver control/status block with program FSM, push FIFOs,
// thresholds, monitor bins and interrupt. Define DRIVER_CNTRL_WDOG_EN to add the program watchdog.
module driver_cntrl_mc #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NUM_MON    = 16,
  parameter int unsigned DEF_THRESH = 820
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [15:0]                       slave_addr,
  input  logic                              slave_rd,
  input  logic                              slave_wr,
  input  logic [31:0]                       slave_data_in,
  output logic [31:0]                       slave_data_out,
  output logic [NUM_CH-1:0]                 ch_fifo_wr,
  output logic [NUM_CH*32-1:0]              ch_fifo_din,
  input  logic [NUM_CH-1:0]                 ch_overrun,
  input  logic [NUM_CH-1:0]                 ch_underrun,
  input  logic [NUM_CH*CNT_W-1:0]           ch_words,
  output logic [NUM_CH*16-1:0]              ch_threshold,
  input  logic [NUM_CH*NUM_MON*CNT_W-1:0]   mon_cnts,
  output logic [NUM_CH-1:0]                 freeze_ch,
  output logic                              active_program,
  output logic                              end_program,
  output logic                              irq
);

  localparam int unsigned CMP_W = (CNT_W > 16) ? CNT_W : 16;
  localparam int unsigned IRQ_W = 2 + NUM_CH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_FROZEN = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Address decode
  logic [13:0] word_addr;
  logic        ch_region, mon_region;
  logic [2:0]  ch_sel, ch_off, mon_ch;
  logic [5:0]  mon_bin;
  logic        unused_addr_lsb;

  assign word_addr       = slave_addr[15:2];
  assign ch_region       = (slave_addr[15:8] == 8'h01);
  assign ch_sel          = slave_addr[7:5];
  assign ch_off          = slave_addr[4:2];
  assign mon_region      = (slave_addr[15:11] == 5'b00001);
  assign mon_ch          = slave_addr[10:8];
  assign mon_bin         = slave_addr[7:2];
  assign unused_addr_lsb = ^slave_addr[1:0];

  logic ctrl_wr, irq_en_wr, irq_stat_wr;
  logic run_p, end_p, abort_p, frz_p, clr_p;

  assign ctrl_wr     = slave_wr && (word_addr == 14'h0000);
  assign irq_en_wr   = slave_wr && (word_addr == 14'h0002);
  assign irq_stat_wr = slave_wr && (word_addr == 14'h0003);
  assign run_p       = ctrl_wr && slave_data_in[0];
  assign end_p       = ctrl_wr && slave_data_in[1];
  assign abort_p     = ctrl_wr && slave_data_in[2];
  assign frz_p       = ctrl_wr && slave_data_in[3];
  assign clr_p       = ctrl_wr && slave_data_in[4];

  logic [NUM_CH-1:0] push_hit, thr_hit, frzr_hit;

  always_comb begin
    push_hit = '0;
    thr_hit  = '0;
    frzr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (slave_wr && ch_region && (ch_sel == 3'(c))) begin
        push_hit[c] = (ch_off == 3'd0);
        thr_hit[c]  = (ch_off == 3'd1);
        frzr_hit[c] = (ch_off == 3'd3);
      end
    end
  end

  logic [NUM_CH-1:0] fault_ch;
  logic              wdog_hit, wdog_cause, err_det;

  assign fault_ch = ch_overrun | ch_underrun;
  assign err_det  = (|fault_ch) || wdog_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, priority abort > error > end > freeze > run
  logic              active_d, end_d;
  logic [NUM_CH-1:0] frz_reg_q, frz_reg_d, freeze_d;

  always_comb begin
    state_d   = state_q;
    active_d  = 1'b0;
    end_d     = 1'b0;
    frz_reg_d = frz_reg_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (frzr_hit[c]) frz_reg_d[c] = slave_data_in[0];
    end
    case (state_q)
      S_IDLE:   if (run_p) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (abort_p)      state_d = S_IDLE;
        else if (err_det) state_d = S_ERROR;
        else if (end_p)   state_d = S_DONE;
        else if (frz_p)   state_d = S_FROZEN;
      end
      S_FROZEN: begin
        if (abort_p)    state_d = S_IDLE;
        else if (end_p) state_d = S_DONE;
        else if (frz_p) state_d = S_ACTIVE;
      end
      S_DONE: begin
        if (abort_p)    state_d = S_IDLE;
        else if (run_p) state_d = S_ACTIVE;
      end
      S_ERROR:  if (abort_p || clr_p) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    active_d = (state_d == S_ACTIVE) || (state_d == S_FROZEN);
    end_d    = (state_d == S_DONE);
    freeze_d = (state_d == S_FROZEN) ? '1 : frz_reg_d;
  end

`ifdef DRIVER_CNTRL_WDOG_EN
  // Watchdog: counts ACTIVE cycles since program start or the last push
  logic        wdog_wr;
  logic [31:0] wdog_limit_q, wdog_cnt_q;
  logic        wdog_cause_q;

  assign wdog_wr    = slave_wr && (word_addr == 14'h0004);
  assign wdog_hit   = (state_q == S_ACTIVE) && (wdog_limit_q != 32'd0) && (wdog_cnt_q == wdog_limit_q);
  assign wdog_cause = wdog_cause_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_limit_q <= '0;
      wdog_cnt_q   <= '0;
      wdog_cause_q <= 1'b0;
    end else begin
      if (wdog_wr) wdog_limit_q <= slave_data_in;
      if ((state_q == S_IDLE || state_q == S_DONE) && state_d == S_ACTIVE) wdog_cnt_q <= '0;
      else if (|push_hit)           wdog_cnt_q <= '0;
      else if (state_q == S_ACTIVE) wdog_cnt_q <= wdog_cnt_q + 32'd1;
      if (state_q == S_ERROR && clr_p) wdog_cause_q <= 1'b0;
      else if (state_q == S_ACTIVE && state_d == S_ERROR && wdog_hit) wdog_cause_q <= 1'b1;
    end
  end
`else
  assign wdog_hit   = 1'b0;
  assign wdog_cause = 1'b0;
`endif

  // Threshold crossing detect: high-or-equal last cycle, below now
  logic [NUM_CH-1:0] above_now, above_q, cross_ev;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
    assign above_now[g] = CMP_W'(ch_words[g*CNT_W +: CNT_W]) >= CMP_W'(ch_threshold[g*16 +: 16]);
  end
  assign cross_ev = above_q & ~above_now;

  logic [IRQ_W-1:0]  irq_en_q, irq_stat_q, irq_stat_d, set_ev;
  logic [NUM_CH-1:0] err_mask_q;
  logic              ev_done, ev_err;

  assign ev_done = (state_d == S_DONE)  && (state_q != S_DONE);
  assign ev_err  = (state_d == S_ERROR) && (state_q != S_ERROR);
  assign set_ev  = {cross_ev, ev_err, ev_done};

  always_comb begin
    irq_stat_d = irq_stat_q;
    if (irq_stat_wr) irq_stat_d = irq_stat_q & ~slave_data_in[IRQ_W-1:0];
    irq_stat_d = irq_stat_d | set_ev;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_fifo_wr     <= '0;
      ch_fifo_din    <= '0;
      ch_threshold   <= {NUM_CH{16'(DEF_THRESH)}};
      frz_reg_q      <= '0;
      freeze_ch      <= '0;
      active_program <= 1'b0;
      end_program    <= 1'b0;
      above_q        <= '0;
      irq_en_q       <= '0;
      irq_stat_q     <= '0;
      irq            <= 1'b0;
      err_mask_q     <= '0;
    end else begin
      ch_fifo_wr <= push_hit;
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_hit[c]) ch_fifo_din[c*32 +: 32]  <= slave_data_in;
        if (thr_hit[c])  ch_threshold[c*16 +: 16] <= slave_data_in[15:0];
      end
      frz_reg_q      <= frz_reg_d;
      freeze_ch      <= freeze_d;
      active_program <= active_d;
      end_program    <= end_d;
      above_q        <= above_now;
      if (irq_en_wr) irq_en_q <= slave_data_in[IRQ_W-1:0];
      irq_stat_q     <= irq_stat_d;
      irq            <= |(irq_stat_q & irq_en_q);
      if (state_q == S_ERROR && clr_p) err_mask_q <= '0;
      else if (state_q == S_ACTIVE && state_d == S_ERROR) err_mask_q <= err_mask_q | fault_ch;
    end
  end

  // Read mux; registered on slave_rd so a same-cycle write is not visible
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (word_addr == 14'h0001) begin
      rd_data = {15'd0, wdog_cause, 8'(err_mask_q), 5'd0, state_q};
    end else if (word_addr == 14'h0002) begin
      rd_data = 32'(irq_en_q);
    end else if (word_addr == 14'h0003) begin
      rd_data = 32'(irq_stat_q);
`ifdef DRIVER_CNTRL_WDOG_EN
    end else if (word_addr == 14'h0004) begin
      rd_data = wdog_limit_q;
`endif
    end else if (ch_region) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 3'(c)) begin
          case (ch_off)
            3'd0:    rd_data = ch_fifo_din[c*32 +: 32];
            3'd1:    rd_data = {16'd0, ch_threshold[c*16 +: 16]};
            3'd2:    rd_data = 32'(ch_words[c*CNT_W +: CNT_W]);
            3'd3:    rd_data = {31'd0, frz_reg_q[c]};
            default: rd_data = '0;
          endcase
        end
      end
    end else if (mon_region) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (mon_ch == 3'(c) && 32'(mon_bin) < NUM_MON)
          rd_data = 32'(mon_cnts[(c*NUM_MON + int'(mon_bin))*CNT_W +: CNT_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        slave_data_out <= '0;
    else if (slave_rd) slave_data_out <= rd_data;
  end

endmodule

// File: tb/tb_driver_cntrl_mc.sv
// Scoreboard bench for driver_cntrl_mc: reads queue expected data, a monitor checks each read
// response; side-band outputs are checked directly around the stimulus.
`timescale 1ns/1ps
module tb_driver_cntrl_mc;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NUM_MON = 16;

  logic                            clk = 1'b0;
  logic                            reset = 1'b0;
  logic [15:0]                     slave_addr = '0;
  logic                            slave_rd = 1'b0;
  logic                            slave_wr = 1'b0;
  logic [31:0]                     slave_data_in = '0;
  logic [31:0]                     slave_data_out;
  logic [NUM_CH-1:0]               ch_fifo_wr;
  logic [NUM_CH*32-1:0]            ch_fifo_din;
  logic [NUM_CH-1:0]               ch_overrun = '0;
  logic [NUM_CH-1:0]               ch_underrun = '0;
  logic [NUM_CH*CNT_W-1:0]         ch_words = '0;
  logic [NUM_CH*16-1:0]            ch_threshold;
  logic [NUM_CH*NUM_MON*CNT_W-1:0] mon_cnts = '0;
  logic [NUM_CH-1:0]               freeze_ch;
  logic                            active_program;
  logic                            end_program;
  logic                            irq;

  always #5 clk = ~clk;

  driver_cntrl_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .NUM_MON(NUM_MON), .DEF_THRESH(820)) dut (
    .clk(clk), .reset(reset), .slave_addr(slave_addr), .slave_rd(slave_rd), .slave_wr(slave_wr),
    .slave_data_in(slave_data_in), .slave_data_out(slave_data_out), .ch_fifo_wr(ch_fifo_wr),
    .ch_fifo_din(ch_fifo_din), .ch_overrun(ch_overrun), .ch_underrun(ch_underrun),
    .ch_words(ch_words), .ch_threshold(ch_threshold), .mon_cnts(mon_cnts), .freeze_ch(freeze_ch),
    .active_program(active_program), .end_program(end_program), .irq(irq)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;
  logic [31:0] exp_v;
  string       name_v;
  int          wd_n;
  int          drain;

  // Monitor: one read response per slave_rd, one cycle later
  always @(posedge clk) rd_seen <= slave_rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got %h with empty scoreboard", slave_data_out);
      end else begin
        exp_v  = exp_q.pop_front();
        name_v = name_q.pop_front();
        if (slave_data_out !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", name_v, slave_data_out, exp_v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    slave_addr    = a;
    slave_data_in = d;
    slave_wr      = 1'b1;
    @(negedge clk);
    slave_wr      = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
    slave_addr = a;
    slave_rd   = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    slave_rd   = 1'b0;
  endtask

  initial begin
    // Monitor bin c,b holds 0x1000*c + b + 5
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < 16; b++)
        mon_cnts[(c*16 + b)*16 +: 16] = 16'(32'h1000*c + b + 5);

    cycles(3);
    chk("rst_data_out", 64'(slave_data_out), 64'h0);
    chk("rst_fifo_wr", 64'(ch_fifo_wr), 64'h0);
    chk("rst_fifo_din", 64'(ch_fifo_din), 64'h0);
    chk("rst_freeze", 64'(freeze_ch), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_thresh", 64'(ch_threshold), 64'h0334_0334);
    reset = 1'b1;
    cycles(1);
    rd(16'h004, 32'h0, "status_reset");
    rd(16'h104, 32'd820, "thresh0_reset");
    rd(16'h124, 32'd820, "thresh1_reset");

    // Reset in the middle of a frozen program
    wr(16'h104, 32'd100);
    wr(16'h000, 32'h1);
    wr(16'h000, 32'h8);
    chk("frozen_freeze", 64'(freeze_ch), 64'h3);
    chk("frozen_active", 64'(active_program), 64'h1);
    rd(16'h004, 32'h2, "status_frozen");
    rd(16'h104, 32'd100, "thresh0_written");
    cycles(2);
    #2 reset = 1'b0;
    #1;
    chk("midrst_freeze", 64'(freeze_ch), 64'h0);
    chk("midrst_irq", 64'(irq), 64'h0);
    chk("midrst_active", 64'(active_program), 64'h0);
    chk("midrst_thresh", 64'(ch_threshold), 64'h0334_0334);
    @(negedge clk);
    reset = 1'b1;
    cycles(1);
    rd(16'h004, 32'h0, "status_after_rst");
    rd(16'h104, 32'd820, "thresh0_after_rst");

    // Push, per-channel and monitor reads
    ch_words = {16'd7, 16'd300};
    wr(16'h120, 32'hDEAD_BEEF);
    chk("push_pulse", 64'(ch_fifo_wr), 64'h2);
    chk("push_din1", 64'(ch_fifo_din[63:32]), 64'hDEAD_BEEF);
    chk("push_din0", 64'(ch_fifo_din[31:0]), 64'h0);
    cycles(1);
    chk("push_pulse_end", 64'(ch_fifo_wr), 64'h0);
    rd(16'h120, 32'hDEAD_BEEF, "push1_readback");
    rd(16'h100, 32'h0, "push0_readback");
    rd(16'h128, 32'd7, "words1");
    rd(16'h108, 32'd300, "words0");
    rd(16'h90C, 32'h1008, "mon_c1_b3");
    rd(16'h800, 32'h5, "mon_c0_b0");
    rd(16'h83C, 32'h14, "mon_c0_b15");
    rd(16'h840, 32'h0, "mon_bin_oob");
    rd(16'hA00, 32'h0, "mon_ch_oob");
    rd(16'h140, 32'h0, "ch_oob");
    rd(16'h110, 32'h0, "ch_off_unmapped");
    // Same-cycle read and write returns the old value
    slave_addr = 16'h124; slave_data_in = 32'd55; slave_wr = 1'b1; slave_rd = 1'b1;
    exp_q.push_back(32'd820); name_q.push_back("rd_wr_same_cycle");
    @(negedge clk);
    slave_wr = 1'b0; slave_rd = 1'b0;
    rd(16'h124, 32'd55, "thresh1_new");

    // Error capture and clear
    wr(16'h000, 32'h1);
    ch_underrun = 2'b10;
    cycles(1);
    ch_underrun = 2'b00;
    chk("error_active", 64'(active_program), 64'h0);
    rd(16'h004, 32'h0204, "status_error");
    wr(16'h000, 32'h10);
    rd(16'h004, 32'h0, "status_cleared");
    wr(16'h000, 32'h1);
    rd(16'h004, 32'h1, "status_rerun");
    rd(16'h00C, 32'h2, "irqstat_err");

    // Freeze, abort and priority
    wr(16'h000, 32'h8);
    chk("freeze_forced", 64'(freeze_ch), 64'h3);
    wr(16'h000, 32'h4);
    chk("abort_freeze", 64'(freeze_ch), 64'h0);
    chk("abort_active", 64'(active_program), 64'h0);
    rd(16'h004, 32'h0, "status_abort");
    wr(16'h000, 32'h1);
    wr(16'h000, 32'h6);
    chk("abort_end_prio", 64'(end_program), 64'h0);
    rd(16'h004, 32'h0, "status_abort_end");
    rd(16'h00C, 32'h2, "irqstat_no_done");
    wr(16'h000, 32'h1);
    wr(16'h000, 32'h2);
    chk("done_end", 64'(end_program), 64'h1);
    rd(16'h004, 32'h3, "status_done");
    rd(16'h00C, 32'h3, "irqstat_done");
    wr(16'h000, 32'h1);
    rd(16'h004, 32'h1, "status_done_rerun");
    wr(16'h000, 32'h8);
    wr(16'h000, 32'h8);
    rd(16'h004, 32'h1, "status_unfreeze");
    wr(16'h000, 32'h4);
    rd(16'h004, 32'h0, "status_idle");
    wr(16'h12C, 32'h1);
    chk("freeze_reg", 64'(freeze_ch), 64'h2);
    rd(16'h12C, 32'h1, "freeze_readback");
    wr(16'h12C, 32'h0);
    wr(16'h00C, 32'hFFFF_FFFF);
    rd(16'h00C, 32'h0, "irqstat_w1c_all");

    // Threshold crossing interrupt
    wr(16'h008, 32'h4);
    rd(16'h008, 32'h4, "irq_en");
    wr(16'h104, 32'd10);
    ch_words[15:0] = 16'd12;
    cycles(1);
    ch_words[15:0] = 16'd9;
    cycles(1);
    chk("irq_lag", 64'(irq), 64'h0);
    cycles(1);
    chk("irq_set", 64'(irq), 64'h1);
    rd(16'h00C, 32'h4, "irqstat_cross");
    ch_words[15:0] = 16'd12;
    cycles(1);
    ch_words[15:0] = 16'd9;
    wr(16'h00C, 32'h4);
    rd(16'h00C, 32'h4, "irqstat_set_wins");
    chk("irq_held", 64'(irq), 64'h1);
    wr(16'h00C, 32'h4);
    rd(16'h00C, 32'h0, "irqstat_w1c");
    cycles(1);
    chk("irq_clear", 64'(irq), 64'h0);
    ch_overrun = 2'b01;
    cycles(1);
    ch_overrun = 2'b00;
    rd(16'h004, 32'h0, "overrun_in_idle");

`ifdef DRIVER_CNTRL_WDOG_EN
    wr(16'h010, 32'd50);
    rd(16'h010, 32'd50, "wdog_limit");
    wr(16'h000, 32'h1);
    wd_n = 0;
    while (active_program && wd_n < 200) begin
      @(negedge clk);
      wd_n++;
    end
    // 50 counted ACTIVE cycles, then the cycle in which the match is seen
    chk("wdog_cycles", 64'(wd_n), 64'd51);
    rd(16'h004, 32'h0001_0004, "status_wdog");
    rd(16'h00C, 32'h2, "irqstat_wdog");
    wr(16'h000, 32'h10);
    rd(16'h004, 32'h0, "status_wdog_clr");
    wr(16'h000, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycles(39);
      wr(16'h100, 32'(i));
    end
    rd(16'h004, 32'h1, "status_wdog_kicked");
    wr(16'h000, 32'h4);
`else
    rd(16'h010, 32'h0, "wdog_absent");
    wr(16'h010, 32'd50);
    rd(16'h010, 32'h0, "wdog_absent_wr");
`endif

    cycles(2);
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      cycles(1);
      drain++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d reads never answered, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
